// File: rtl/nexys_starship_pkg.sv
// Shared types and constants for the Nexys Starship monster lanes and spawn scheduler.
package nexys_starship_pkg;

  typedef enum logic [2:0] {
    INIT = 3'b001,
    PLAY = 3'b010,
    OVER = 3'b100
  } state_t;

  localparam logic [1:0] LANE_TOP = 2'd0;
  localparam logic [1:0] LANE_BTM = 2'd1;
  localparam logic [1:0] LANE_LFT = 2'd2;
  localparam logic [1:0] LANE_RGT = 2'd3;

  // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic       found;
    logic [1:0] lane;
  } lane_pick_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/nexys_starship_lfsr.sv
// Free-running 8-bit Galois LFSR; shared by the scheduler and the lane blocks.
module nexys_starship_lfsr
  import nexys_starship_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [7:0] q
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q <= SEED;
    end else begin
      q <= {1'b0, q[7:1]} ^ (q[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/nexys_starship_monster_sched.sv
// Spawn scheduler: picks a lane for each new monster, caps concurrency,
// ramps spawn rate with kills and merges lane game-over flags.
module nexys_starship_monster_sched
  import nexys_starship_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned MAX_ACTIVE    = 2,
  parameter int unsigned INIT_INTERVAL = 6,
  parameter int unsigned MIN_INTERVAL  = 2,
  parameter int unsigned RAMP_KILLS    = 8,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 play_flag,
  input  logic                 timer_tick,
  input  logic [NUM_LANES-1:0] lane_full,
  input  logic [NUM_LANES-1:0] lane_killed,
  input  logic [NUM_LANES-1:0] lane_gameover,
  output logic [NUM_LANES-1:0] spawn,
  output logic                 gameover,
  output logic [2:0]           active_count,
  output logic [3:0]           interval,
  output logic [7:0]           kill_count,
  output logic                 q_Init,
  output logic                 q_Play,
  output logic                 q_Over
);

  state_t      state;
  logic [3:0]  countdown;
  logic [3:0]  ramp_cnt;
  logic [7:0]  lfsr_q;
  logic        lfsr_unused;

  logic [2:0]  kills;
  logic [8:0]  kill_sum;
  logic [7:0]  kill_next;
  logic [4:0]  ramp_sum;
  logic [3:0]  ramp_next;
  logic [3:0]  interval_next;
  lane_pick_t  pick;
  logic        spawn_ok;

  nexys_starship_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .q     (lfsr_q)
  );

  // Only the two low LFSR bits choose the candidate lane.
  assign lfsr_unused = ^lfsr_q[7:2];

  assign {q_Over, q_Play, q_Init} = state;

  // First empty lane at or after the candidate, wrapping modulo 4.
  function automatic lane_pick_t find_empty(input logic [3:0] full,
                                            input logic [1:0] start);
    lane_pick_t p;
    logic [1:0] idx;
    p.found = 1'b0;
    p.lane  = start;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!p.found && !full[idx]) begin
        p.found = 1'b1;
        p.lane  = idx;
      end
    end
    return p;
  endfunction

  always_comb begin
    kills         = popcount4(lane_killed);
    kill_sum      = {1'b0, kill_count} + 9'(kills);
    kill_next     = kill_sum[8] ? 8'hFF : kill_sum[7:0];
    ramp_sum      = {1'b0, ramp_cnt} + 5'(kills);
    ramp_next     = ramp_sum[3:0];
    interval_next = interval;
    if (ramp_sum >= 5'(RAMP_KILLS)) begin
      ramp_next = 4'(ramp_sum - 5'(RAMP_KILLS));
      if (interval > 4'(MIN_INTERVAL)) begin
        interval_next = interval - 4'd1;
      end
    end
    pick     = find_empty(lane_full, lfsr_q[1:0]);
    spawn_ok = pick.found && (active_count < 3'(MAX_ACTIVE));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= INIT;
      spawn        <= '0;
      gameover     <= 1'b0;
      active_count <= '0;
      kill_count   <= '0;
      ramp_cnt     <= '0;
      interval     <= 4'(INIT_INTERVAL);
      countdown    <= 4'(INIT_INTERVAL);
    end else begin
      active_count <= popcount4(lane_full);
      spawn        <= '0;
      case (state)
        INIT: begin
          gameover   <= 1'b0;
          interval   <= 4'(INIT_INTERVAL);
          countdown  <= 4'(INIT_INTERVAL);
          kill_count <= '0;
          ramp_cnt   <= '0;
          if (play_flag) begin
            state <= PLAY;
          end
        end
        PLAY: begin
          kill_count <= kill_next;
          ramp_cnt   <= ramp_next;
          interval   <= interval_next;
          if (|lane_gameover) begin
            state    <= OVER;
            gameover <= 1'b1;
          end else if (!play_flag) begin
            state <= INIT;
          end else if (timer_tick) begin
            if (countdown != '0) begin
              countdown <= countdown - 4'd1;
            end else if (spawn_ok) begin
              // Reload from the pre-ramp interval so an in-flight change never shortens this wait.
              spawn     <= 4'b0001 << pick.lane;
              countdown <= interval - 4'd1;
            end
          end
        end
        OVER: begin
          gameover <= 1'b1;
          if (!play_flag) begin
            state    <= INIT;
            gameover <= 1'b0;
          end
        end
        default: begin
          state    <= INIT;
          gameover <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nexys_starship_monster_sched.sv
// Directed self-checking bench for the monster spawn scheduler.
module tb_nexys_starship_monster_sched;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       play_flag;
  logic       timer_tick;
  logic [3:0] lane_full;
  logic [3:0] lane_killed;
  logic [3:0] lane_gameover;
  logic [3:0] spawn;
  logic       gameover;
  logic [2:0] active_count;
  logic [3:0] interval;
  logic [7:0] kill_count;
  logic       q_Init, q_Play, q_Over;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_lfsr;

  nexys_starship_monster_sched #(
    .NUM_LANES     (4),
    .MAX_ACTIVE    (2),
    .INIT_INTERVAL (6),
    .MIN_INTERVAL  (2),
    .RAMP_KILLS    (8),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .play_flag     (play_flag),
    .timer_tick    (timer_tick),
    .lane_full     (lane_full),
    .lane_killed   (lane_killed),
    .lane_gameover (lane_gameover),
    .spawn         (spawn),
    .gameover      (gameover),
    .active_count  (active_count),
    .interval      (interval),
    .kill_count    (kill_count),
    .q_Init        (q_Init),
    .q_Play        (q_Play),
    .q_Over        (q_Over)
  );

  always #5 Clk = ~Clk;

  // Reference LFSR: right-shift Galois form of x^8+x^6+x^5+x^4+1.
  always @(posedge Clk) begin
    if (Reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  end

  function automatic logic [3:0] exp_spawn(input logic [3:0] full, input logic [1:0] cand);
    logic [1:0] idx;
    for (int k = 0; k < 4; k++) begin
      idx = cand + 2'(k);
      if (!full[idx]) return 4'b0001 << idx;
    end
    return 4'b0000;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_tick(output logic [3:0] sp, output logic [1:0] cand, output logic idle_sp);
    cand = m_lfsr[1:0];
    timer_tick = 1'b1;
    step();
    sp = spawn;
    timer_tick = 1'b0;
    idle_sp = 1'b0;
    repeat (3) begin
      step();
      idle_sp = idle_sp | (|spawn);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; play_flag = 0; timer_tick = 0;
    lane_full = '0; lane_killed = '0; lane_gameover = '0;
    step(); step();
    tests++; if ({q_Over, q_Play, q_Init} !== 3'b001) begin fails++; $display("FAIL reset_state got %b want 001", {q_Over, q_Play, q_Init}); end
    tests++; if (spawn !== 4'b0000 || gameover !== 1'b0) begin fails++; $display("FAIL reset_outputs spawn=%b gameover=%b want 0000/0", spawn, gameover); end
    tests++; if (interval !== 4'd6 || kill_count !== 8'd0 || active_count !== 3'd0) begin fails++; $display("FAIL reset_counts interval=%0d kills=%0d active=%0d want 6/0/0", interval, kill_count, active_count); end
    tests++; if (dut.lfsr_q !== 8'hA5) begin fails++; $display("FAIL reset_lfsr got %h want a5", dut.lfsr_q); end
    Reset = 1'b0;
  endtask

  task automatic test_first_spawn();
    logic [3:0] sp; logic [1:0] cand; logic idle; int pulses;
    play_flag = 1'b1; lane_full = 4'b0000;
    step();
    tests++; if (q_Play !== 1'b1) begin fails++; $display("FAIL enter_play q_Play=%b want 1", q_Play); end
    pulses = 0;
    for (int t = 1; t <= 7; t++) begin
      do_tick(sp, cand, idle);
      if (sp != 0) pulses++;
      if (idle) pulses++;
      if (t == 7) begin
        tests++; if (sp !== exp_spawn(4'b0000, cand)) begin fails++; $display("FAIL first_spawn_lane got %b want %b", sp, exp_spawn(4'b0000, cand)); end
      end
    end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL first_spawn_count got %0d want 1", pulses); end
    tests++; if (dut.lfsr_q !== m_lfsr) begin fails++; $display("FAIL lfsr_track got %h want %h", dut.lfsr_q, m_lfsr); end
  endtask

  task automatic test_wrap();
    logic [3:0] sp; logic [1:0] cand; logic idle; int guard; int bad;
    lane_full = 4'b1111; bad = 0;
    repeat (5) begin do_tick(sp, cand, idle); if (sp != 0 || idle) bad++; end
    tests++; if (bad !== 0) begin fails++; $display("FAIL countdown_no_spawn got %0d spawns want 0", bad); end
    lane_full = 4'b0000;
    step();
    guard = 0;
    while (m_lfsr[1:0] != 2'd1 && guard < 64) begin step(); guard++; end
    tests++; if (guard >= 64) begin fails++; $display("FAIL wrap_wait got timeout want candidate 1"); end
    lane_full = 4'b0111;
    do_tick(sp, cand, idle);
    tests++; if (sp !== 4'b1000) begin fails++; $display("FAIL wrap_search got %b want 1000", sp); end
    tests++; if (active_count !== 3'd3) begin fails++; $display("FAIL active_count got %0d want 3", active_count); end
  endtask

  task automatic test_max_active();
    logic [3:0] sp; logic [1:0] cand; logic idle; int bad;
    lane_full = 4'b0011; bad = 0;
    repeat (5) begin do_tick(sp, cand, idle); if (sp != 0 || idle) bad++; end
    repeat (3) begin do_tick(sp, cand, idle); if (sp != 0 || idle) bad++; end
    tests++; if (bad !== 0) begin fails++; $display("FAIL max_active_block got %0d spawns want 0", bad); end
    lane_full = 4'b0001;
    step();
    do_tick(sp, cand, idle);
    tests++; if (sp !== exp_spawn(4'b0001, cand)) begin fails++; $display("FAIL retry_spawn got %b want %b", sp, exp_spawn(4'b0001, cand)); end
  endtask

  task automatic test_kills();
    repeat (3) begin lane_killed = 4'b0011; step(); lane_killed = 4'b0000; step(); end
    tests++; if (kill_count !== 8'd6 || interval !== 4'd6) begin fails++; $display("FAIL kills_6 got %0d/%0d want 6/6", kill_count, interval); end
    lane_killed = 4'b0011; step(); lane_killed = 4'b0000; step();
    tests++; if (kill_count !== 8'd8 || interval !== 4'd5) begin fails++; $display("FAIL kills_8 got %0d/%0d want 8/5", kill_count, interval); end
    repeat (8) begin lane_killed = 4'b1111; step(); end
    lane_killed = 4'b0000; step();
    tests++; if (kill_count !== 8'd40 || interval !== 4'd2) begin fails++; $display("FAIL kills_40 got %0d/%0d want 40/2", kill_count, interval); end
  endtask

  task automatic test_gameover();
    logic [3:0] sp; logic [1:0] cand; logic idle;
    lane_full = 4'b1111;
    repeat (5) do_tick(sp, cand, idle);
    lane_full = 4'b0000;
    step();
    timer_tick = 1'b1; lane_gameover = 4'b0010;
    step();
    timer_tick = 1'b0;
    tests++; if (spawn !== 4'b0000 || gameover !== 1'b1 || q_Over !== 1'b1) begin fails++; $display("FAIL gameover_priority spawn=%b gameover=%b q_Over=%b want 0000/1/1", spawn, gameover, q_Over); end
    lane_killed = 4'b0011; step(); lane_killed = 4'b0000; step();
    tests++; if (kill_count !== 8'd40) begin fails++; $display("FAIL over_freeze got %0d want 40", kill_count); end
    lane_gameover = 4'b0000; play_flag = 1'b0;
    step();
    tests++; if (q_Init !== 1'b1 || gameover !== 1'b0) begin fails++; $display("FAIL over_exit q_Init=%b gameover=%b want 1/0", q_Init, gameover); end
  endtask

  task automatic test_reset_mid_spawn();
    logic [3:0] sp; logic [1:0] cand; logic idle;
    play_flag = 1'b1; lane_full = 4'b0000;
    step();
    repeat (4) begin lane_killed = 4'b0011; step(); lane_killed = 4'b0000; step(); end
    repeat (6) do_tick(sp, cand, idle);
    timer_tick = 1'b1;
    step();
    timer_tick = 1'b0;
    tests++; if (spawn === 4'b0000 || interval !== 4'd5 || kill_count !== 8'd8) begin fails++; $display("FAIL pre_reset spawn=%b interval=%0d kills=%0d want nonzero/5/8", spawn, interval, kill_count); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    tests++; if (spawn !== 4'b0000 || q_Init !== 1'b1) begin fails++; $display("FAIL reset_mid_spawn spawn=%b q_Init=%b want 0000/1", spawn, q_Init); end
    tests++; if (dut.lfsr_q !== 8'hA5 || kill_count !== 8'd0 || interval !== 4'd6) begin fails++; $display("FAIL reset_mid_state lfsr=%h kills=%0d interval=%0d want a5/0/6", dut.lfsr_q, kill_count, interval); end
  endtask

  task automatic test_saturation();
    int bad_hot; int bad_idle;
    play_flag = 1'b1; lane_full = 4'b0000;
    step();
    bad_hot = 0; bad_idle = 0;
    for (int i = 0; i < 260; i++) begin
      lane_killed = 4'b0001 << (i % 4);
      timer_tick = (i % 4 == 0);
      step();
      if ($countones(spawn) > 1) bad_hot++;
      if ((i % 4 != 0) && spawn != 0) bad_idle++;
      if (i == 199) begin
        tests++; if (kill_count !== 8'd200) begin fails++; $display("FAIL kills_200 got %0d want 200", kill_count); end
      end
    end
    lane_killed = 4'b0000; timer_tick = 1'b0;
    step();
    tests++; if (kill_count !== 8'd255) begin fails++; $display("FAIL kill_saturate got %0d want 255", kill_count); end
    tests++; if (bad_hot !== 0) begin fails++; $display("FAIL spawn_onehot got %0d violations want 0", bad_hot); end
    tests++; if (bad_idle !== 0) begin fails++; $display("FAIL spawn_no_tick got %0d violations want 0", bad_idle); end
    tests++; if (interval !== 4'd2) begin fails++; $display("FAIL interval_floor got %0d want 2", interval); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_spawn();
    test_wrap();
    test_max_active();
    test_kills();
    test_gameover();
    test_reset_mid_spawn();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
